dram_fetch_ctrl: RTL and testbench
==================================

// Module: dram_fetch_ctrl
// PURPOSE
//  Read-side initiator for the 19-bit-address / 392-bit-row DRAM model (49 x 8-bit window per row).
//  On start, issues a sequence of row reads (base, base+stride, ...), captures returned rows, and
//  streams them downstream on a valid/ready interface. Credit-limited so no returned row is ever dropped.
//  Sits between the compute-array loader and the DRAM; the write path is untouched.
// PARAMETERS
//  ADDR_W      19   DRAM row address width
//  DATA_W      392  DRAM read row width (49 bytes)
//  RD_LAT      1    cycles from ren sampled high to rdata valid at DRAM output (>=1)
//  FIFO_DEPTH  4    return buffer entries (power of 2, >= RD_LAT+1)
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       1-cycle request to begin a fetch; sampled only in IDLE
//  base_addr   in   ADDR_W  first row address, captured on accepted start
//  stride      in   ADDR_W  address increment per row, captured on accepted start
//  num_rows    in   ADDR_W  rows to fetch, captured on accepted start; 0 allowed
//  busy        out  1       high from accepted start until done
//  done        out  1       1-cycle pulse after last row handshaken downstream
//  dram_ren    out  1       DRAM read enable
//  dram_raddr  out  ADDR_W  DRAM read address, meaningful when dram_ren=1
//  dram_rdata  in   DATA_W  DRAM read data, valid RD_LAT cycles after dram_ren sampled
//  out_valid   out  1       row available
//  out_data    out  DATA_W  row payload
//  out_last    out  1       qualifies final row of the fetch
//  out_ready   in   1       downstream accept; transfer when out_valid & out_ready
// BEHAVIOUR
//  Reset: busy=0, done=0, dram_ren=0, dram_raddr=0, out_valid=0, out_last=0, FIFO empty, FSM IDLE.
//  FSM: IDLE -> (start & num_rows!=0) ISSUE; IDLE -> (start & num_rows==0) DONE.
//       ISSUE -> DRAIN once issued_cnt==num_rows; DRAIN -> DONE when last row transferred; DONE -> IDLE.
//       done asserted for exactly the one cycle in DONE; busy=1 in ISSUE and DRAIN (and DONE).
//  start outside IDLE is ignored; captured base/stride/num_rows are stable for the whole fetch.
//  Issue: dram_ren=1 in cycle N only if in ISSUE and (inflight + fifo_count) < FIFO_DEPTH;
//         at most one read per cycle; back-to-back reads allowed (1 row/clk peak throughput).
//  Address: row k uses base_addr + k*stride, computed by running accumulator, wraps modulo 2^ADDR_W.
//  Return tracking: RD_LAT-deep valid shift register; bit out = write dram_rdata into FIFO that edge.
//  inflight = number of set bits in the shift register; credit check counts a same-cycle pop as freed.
//  FIFO: first-word-fall-through; out_valid = !empty; simultaneous push and pop on full or empty legal.
//  out_last = out_valid & (this row index == num_rows-1); row index counts handshakes, not issues.
//  out_ready may drop at any time; issue stalls when credits exhausted, never overflows FIFO.
//  Rows delivered strictly in issue order; out_data held stable while out_valid & !out_ready.
//  Reset mid-fetch: all state cleared immediately; returns already in flight are discarded.
// STRUCTURE
//  Shared package dram_if_pkg: ADDR_W=19, DATA_W=392, BYTES_PER_ROW=49, FSM state enum.
//  One sub-module: fetch_fifo (sync FWFT FIFO, DEPTH/WIDTH params, count output).
//  Top holds FSM, address accumulator, issue/handshake counters, latency shift register.
// TESTING
//  Behavioural DRAM model with rdata = f(addr) pattern; scoreboard checks order, payload, last.
//  1 basic: base=0,stride=1,num_rows=5,out_ready=1 -> raddr 0..4 on 5 consecutive cycles,
//    5 rows in order, out_last on 5th, done one cycle after it.
//  2 backpressure: num_rows=10, out_ready=0 -> exactly FIFO_DEPTH reads issued then ren low;
//    release out_ready -> remaining 6 issued, all 10 delivered, none lost or duplicated.
//  3 wrap: base=19'h7FFFE,stride=1,num_rows=4 -> raddr 7FFFE,7FFFF,00000,00001.
//  4 zero/ignored: num_rows=0 -> no dram_ren, done pulses 1 cycle later;
//    start pulsed while busy -> ignored, captured params unchanged.
//  5 reset mid-op: rst_n low during ISSUE with 2 reads in flight -> all outputs at reset values
//    at once; next start fetches cleanly with no stale rows.
//  6 random out_ready (50%), stride=7,num_rows=64, RD_LAT=1 and 3 -> scoreboard clean.

Source files
------------

// File: rtl/dram_if_pkg.sv
// Shared definitions for the DRAM row-fetch path: bus widths and the fetch FSM states.
package dram_if_pkg;
   localparam int ADDR_W        = 19;
   localparam int BYTES_PER_ROW = 49;
   localparam int DATA_W        = BYTES_PER_ROW * 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_e;
endpackage

// File: rtl/dram_fetch_ctrl_if.sv
// DRAM read port plus the downstream row stream, bundled for the fetch controller.
interface dram_fetch_ctrl_if;
   import dram_if_pkg::*;

   logic              dram_ren;
   logic [ADDR_W-1:0] dram_raddr;
   logic [DATA_W-1:0] dram_rdata;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   // Controller side: drives reads and the stream
   modport master (
      output dram_ren, dram_raddr,
      input  dram_rdata,
      output out_valid, out_data, out_last,
      input  out_ready
   );

   // DRAM / consumer side
   modport slave (
      input  dram_ren, dram_raddr,
      output dram_rdata,
      input  out_valid, out_data, out_last,
      output out_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned DRAM rows.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 392
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Pop needs data; push needs room, where a same-cycle pop counts as room
   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push & ((count_q != FULL_CNT) | do_pop);
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Row storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   assign pop_data = mem[rd_ptr_q];
   assign empty    = (count_q == '0);
   assign count    = count_q;
endmodule

// File: rtl/dram_fetch_ctrl.sv
// Strided DRAM row reader: issues credit-limited reads and streams returned rows in order.
module dram_fetch_ctrl
   import dram_if_pkg::*;
#(
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] stride,
   input  logic [ADDR_W-1:0] num_rows,
   output logic              busy,
   output logic              done,
   dram_fetch_ctrl_if.master bus
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] rows_q, rows_d;
   logic [ADDR_W-1:0] issued_q, issued_d;
   logic [ADDR_W-1:0] deliv_q, deliv_d;
   logic [RD_LAT-1:0] lat_sr_q, lat_sr_d;

   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [DATA_W-1:0] fifo_data;
   logic [OCC_W-1:0]  occupancy;
   logic              credit_ok, ren, pop, push, is_last;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (bus.dram_rdata),
      .pop       (pop),
      .pop_data  (fifo_data),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign push          = lat_sr_q[RD_LAT-1];
   assign pop           = !fifo_empty && bus.out_ready;
   assign is_last       = !fifo_empty && (deliv_q == rows_q - ADDR_W'(1));
   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = fifo_data;
   assign bus.out_last  = is_last;
   assign bus.dram_ren  = ren;
   assign bus.dram_raddr = addr_q;
   assign busy          = (state_q != ST_IDLE);
   assign done          = (state_q == ST_DONE);

   // Credit check: rows committed (in flight + buffered) less the row leaving this cycle
   always_comb begin
      occupancy = OCC_W'(fifo_count) - OCC_W'(pop);
      for (int i = 0; i < RD_LAT; i++) begin
         occupancy = occupancy + OCC_W'(lat_sr_q[i]);
      end
      credit_ok = (occupancy < OCC_W'(FIFO_DEPTH));
      ren       = (state_q == ST_ISSUE) && (issued_q != rows_q) && credit_ok;
      lat_sr_d  = RD_LAT'({lat_sr_q, ren});
   end

   // Next-state, parameter capture, address accumulator and issue/handshake counters
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      rows_d   = rows_q;
      issued_d = issued_q;
      deliv_d  = deliv_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d   = base_addr;
               stride_d = stride;
               rows_d   = num_rows;
               issued_d = '0;
               deliv_d  = '0;
               state_d  = (num_rows == '0) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ren) begin
               addr_d   = addr_q + stride_q;
               issued_d = issued_q + ADDR_W'(1);
               // Leave on the final issue so the last return can never be missed
               if (issued_q + ADDR_W'(1) == rows_q) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && is_last) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (pop) begin
         deliv_d = deliv_q + ADDR_W'(1);
      end
   end

   // State registers; reset discards everything, including returns still in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         rows_q   <= '0;
         issued_q <= '0;
         deliv_q  <= '0;
         lat_sr_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         rows_q   <= rows_d;
         issued_q <= issued_d;
         deliv_q  <= deliv_d;
         lat_sr_q <= lat_sr_d;
      end
   end
endmodule

// File: tb/tb_dram_fetch_ctrl.sv
// Bench: two controllers (read latency 1 and 3) share stimulus; each has its own DRAM model.
module tb_dram_fetch_ctrl;
   import dram_if_pkg::*;

   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_in, stride_in, nrows_in;
   logic              out_ready;
   bit                rnd_mode;

   logic [1:0]             busy_a, done_a, ren_a, valid_a, last_a;
   logic [1:0][ADDR_W-1:0] raddr_a;
   logic [1:0][DATA_W-1:0] data_a;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // reference model state, per DUT
   bit          exp_busy [2];
   bit          exp_done [2];
   int          issued   [2];
   int          deliv    [2];
   int          nrows    [2];
   int unsigned base_m   [2];
   int unsigned stride_m [2];
   int          icyc     [2][256];

   // observation logs for literal checks
   int ren_log [$];
   int ren_cyc [$];
   int ren_cnt [2];
   int hs_cnt  [2];
   int done_cyc;
   int last_hs_cyc;

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] row_pattern(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] r;
      for (int b = 0; b < BYTES_PER_ROW; b++) begin
         r[b*8 +: 8] = 8'(a >> (b % 12)) ^ 8'(b * 29 + 1);
      end
      return r;
   endfunction

   function automatic int addr_of(input int d, input int k);
      return int'(ADDR_W'(base_m[d] + stride_m[d] * k));
   endfunction

   task automatic check_int(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   task automatic check_vec(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic              busy_w, done_w;
      logic [ADDR_W-1:0] pipe [LAT];

      dram_fetch_ctrl_if bus_i ();

      dram_fetch_ctrl #(.RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start),
         .base_addr (base_in),
         .stride    (stride_in),
         .num_rows  (nrows_in),
         .busy      (busy_w),
         .done      (done_w),
         .bus       (bus_i)
      );

      // DRAM model: registered read path LAT cycles deep, data is a function of the address
      always @(posedge clk) begin
         pipe[0] <= bus_i.dram_raddr;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign bus_i.dram_rdata = row_pattern(pipe[LAT-1]);
      assign bus_i.out_ready  = out_ready;

      assign busy_a[gi]  = busy_w;
      assign done_a[gi]  = done_w;
      assign ren_a[gi]   = bus_i.dram_ren;
      assign raddr_a[gi] = bus_i.dram_raddr;
      assign valid_a[gi] = bus_i.out_valid;
      assign last_a[gi]  = bus_i.out_last;
      assign data_a[gi]  = bus_i.out_data;
   end

   // Per-cycle compare against the model, then advance the model to the next cycle
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int lat;
         bit exp_valid, pop, exp_ren, nb, nd;
         lat = (d == 0) ? 1 : 3;
         if (!rst_n) begin
            check_int($sformatf("dut%0d rst ren", d),   int'(ren_a[d]),   0);
            check_int($sformatf("dut%0d rst raddr", d), int'(raddr_a[d]), 0);
            check_int($sformatf("dut%0d rst busy", d),  int'(busy_a[d]),  0);
            check_int($sformatf("dut%0d rst done", d),  int'(done_a[d]),  0);
            check_int($sformatf("dut%0d rst valid", d), int'(valid_a[d]), 0);
            check_int($sformatf("dut%0d rst last", d),  int'(last_a[d]),  0);
            exp_busy[d] = 0; exp_done[d] = 0;
            issued[d] = 0; deliv[d] = 0; nrows[d] = 0;
         end else begin
            exp_valid = (deliv[d] < issued[d]) && (icyc[d][deliv[d]] + 1 + lat <= cyc);
            pop       = exp_valid && out_ready;
            exp_ren   = exp_busy[d] && !exp_done[d] && (issued[d] < nrows[d]) &&
                        ((issued[d] - deliv[d] - int'(pop)) < DEPTH);
            check_int($sformatf("dut%0d busy c%0d", d, cyc),  int'(busy_a[d]),  int'(exp_busy[d]));
            check_int($sformatf("dut%0d done c%0d", d, cyc),  int'(done_a[d]),  int'(exp_done[d]));
            check_int($sformatf("dut%0d ren c%0d", d, cyc),   int'(ren_a[d]),   int'(exp_ren));
            check_int($sformatf("dut%0d valid c%0d", d, cyc), int'(valid_a[d]), int'(exp_valid));
            if (exp_ren)
               check_int($sformatf("dut%0d raddr row%0d", d, issued[d]), int'(raddr_a[d]), addr_of(d, issued[d]));
            if (exp_valid) begin
               check_vec($sformatf("dut%0d data row%0d", d, deliv[d]), data_a[d],
                         row_pattern(ADDR_W'(addr_of(d, deliv[d]))));
               check_int($sformatf("dut%0d last row%0d", d, deliv[d]), int'(last_a[d]),
                         int'(deliv[d] == nrows[d] - 1));
            end
            nb = exp_busy[d];
            nd = 0;
            if (exp_ren) begin
               icyc[d][issued[d]] = cyc;
               issued[d]++;
            end
            if (pop) begin
               deliv[d]++;
               if (deliv[d] == nrows[d]) nd = 1;
            end
            if (exp_done[d]) nb = 0;
            if (!exp_busy[d] && start) begin
               base_m[d]   = base_in;
               stride_m[d] = stride_in;
               nrows[d]    = int'(nrows_in);
               issued[d]   = 0;
               deliv[d]    = 0;
               nb          = 1;
               if (nrows_in == '0) nd = 1;
            end
            exp_busy[d] = nb;
            exp_done[d] = nd;
         end
         if (ren_a[d]) ren_cnt[d]++;
         if (valid_a[d] && out_ready) hs_cnt[d]++;
      end
      if (ren_a[0]) begin
         ren_log.push_back(int'(raddr_a[0]));
         ren_cyc.push_back(cyc);
      end
      if (done_a[0]) done_cyc = cyc;
      if (valid_a[0] && out_ready && last_a[0]) last_hs_cyc = cyc;
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic clear_logs();
      ren_log.delete();
      ren_cyc.delete();
      ren_cnt = '{0, 0};
      hs_cnt  = '{0, 0};
      done_cyc = -1;
      last_hs_cyc = -100;
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] n);
      start = 1'b1; base_in = b; stride_in = s; nrows_in = n;
      step();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while ((exp_busy[0] || exp_busy[1]) && n < budget) begin
         step();
         n++;
      end
      if (exp_busy[0] || exp_busy[1]) begin
         n_checks++;
         $display("FAIL %s timeout: still busy after %0d cycles, required idle", tag, budget);
      end
   endtask

   initial begin
      int st;
      rst_n = 1'b1; start = 1'b0; base_in = '0; stride_in = '0; nrows_in = '0;
      out_ready = 1'b1; rnd_mode = 0;
      clear_logs();
      #2 rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // 1 basic
      clear_logs();
      fetch(19'd0, 19'd1, 19'd5);
      wait_idle(100, "t1");
      check_int("t1 ren count", ren_log.size(), 5);
      for (int i = 0; i < 5 && i < ren_log.size(); i++) begin
         check_int($sformatf("t1 raddr%0d", i), ren_log[i], i);
         check_int($sformatf("t1 ren cycle%0d", i), ren_cyc[i] - ren_cyc[0], i);
      end
      check_int("t1 done after last", done_cyc - last_hs_cyc, 1);
      $display("t1 basic: %0d reads, done at cycle %0d", ren_log.size(), done_cyc);

      // 2 backpressure
      clear_logs();
      out_ready = 1'b0;
      fetch(19'd100, 19'd1, 19'd10);
      repeat (15) step();
      check_int("t2 stalled reads lat1", ren_cnt[0], DEPTH);
      check_int("t2 stalled reads lat3", ren_cnt[1], DEPTH);
      out_ready = 1'b1;
      wait_idle(200, "t2");
      check_int("t2 total reads lat1", ren_cnt[0], 10);
      check_int("t2 delivered lat1", hs_cnt[0], 10);
      check_int("t2 delivered lat3", hs_cnt[1], 10);
      $display("t2 backpressure: %0d/%0d rows delivered", hs_cnt[0], hs_cnt[1]);

      // 3 address wrap
      clear_logs();
      fetch(19'h7FFFE, 19'd1, 19'd4);
      wait_idle(100, "t3");
      check_int("t3 ren count", ren_log.size(), 4);
      if (ren_log.size() == 4) begin
         check_int("t3 raddr0", ren_log[0], 'h7FFFE);
         check_int("t3 raddr1", ren_log[1], 'h7FFFF);
         check_int("t3 raddr2", ren_log[2], 'h00000);
         check_int("t3 raddr3", ren_log[3], 'h00001);
      end
      $display("t3 wrap: %0d reads", ren_log.size());

      // 4 zero rows, then start while busy
      clear_logs();
      st = cyc;
      fetch(19'd5, 19'd1, 19'd0);
      wait_idle(20, "t4a");
      check_int("t4 zero ren", ren_cnt[0] + ren_cnt[1], 0);
      check_int("t4 zero done cycle", done_cyc - st, 1);
      clear_logs();
      fetch(19'd0, 19'd3, 19'd10);
      repeat (3) step();
      start = 1'b1; base_in = 19'd100; stride_in = 19'd5; nrows_in = 19'd2;
      step();
      start = 1'b0;
      wait_idle(200, "t4b");
      check_int("t4 ignored start reads", ren_cnt[0], 10);
      if (ren_log.size() == 10) check_int("t4 last raddr", ren_log[9], 27);
      check_int("t4 delivered lat3", hs_cnt[1], 10);
      $display("t4 zero/ignored: %0d reads", ren_cnt[0]);

      // 5 reset mid-fetch
      clear_logs();
      fetch(19'd0, 19'd1, 19'd10);
      step();
      step();
      rst_n = 1'b0;
      #1;
      check_int("t5 async ren", int'(ren_a[0]), 0);
      check_int("t5 async busy", int'(busy_a[1]), 0);
      check_int("t5 async valid", int'(valid_a[0]), 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      clear_logs();
      fetch(19'h40, 19'd2, 19'd6);
      wait_idle(100, "t5");
      check_int("t5 first raddr", (ren_log.size() > 0) ? ren_log[0] : -1, 'h40);
      check_int("t5 delivered lat1", hs_cnt[0], 6);
      check_int("t5 delivered lat3", hs_cnt[1], 6);
      $display("t5 reset: %0d rows after restart", hs_cnt[0]);

      // 6 random ready, long strided fetch, then random fetches
      rnd_mode = 1;
      clear_logs();
      fetch(ADDR_W'($urandom), 19'd7, 19'd64);
      wait_idle(2000, "t6");
      check_int("t6 delivered lat1", hs_cnt[0], 64);
      check_int("t6 delivered lat3", hs_cnt[1], 64);
      $display("t6 random ready: %0d/%0d rows", hs_cnt[0], hs_cnt[1]);
      for (int k = 0; k < 6; k++) begin
         fetch(ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom_range(0, 20)));
         wait_idle(600, "t6r");
         $display("t6 random fetch %0d: base=%0h stride=%0h rows=%0d", k, base_m[0], stride_m[0], nrows[0]);
      end
      rnd_mode = 0;
      out_ready = 1'b1;
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
